// File: rtl/rs_syndrome_calc.sv
// One RS(204,188) syndrome over GF(2^8) (poly 0x11D): Horner evaluation of the
// received block at alpha^Alpha_i, one symbol per accepted clock, frozen after N symbols.
module rs_syndrome_calc #(
    parameter int N = 204
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Msg_Rsv,
    input  logic [4:0] Alpha_i,
    input  logic       CS,
    output logic       done,
    output logic [7:0] S_i
);

    localparam logic [7:0] LAST = 8'(N - 1);

    logic [7:0] acc;
    logic [7:0] cnt;
    logic [7:0] alpha_k;
    logic [7:0] prod;
    logic       accept;

    // Shift-and-add multiply; each doubling folds bit 8 back in via the low byte of 0x11D.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    always_comb begin
        alpha_k = 8'h01;
        case (Alpha_i)
            5'd0:  alpha_k = 8'h01;
            5'd1:  alpha_k = 8'h02;
            5'd2:  alpha_k = 8'h04;
            5'd3:  alpha_k = 8'h08;
            5'd4:  alpha_k = 8'h10;
            5'd5:  alpha_k = 8'h20;
            5'd6:  alpha_k = 8'h40;
            5'd7:  alpha_k = 8'h80;
            5'd8:  alpha_k = 8'h1D;
            5'd9:  alpha_k = 8'h3A;
            5'd10: alpha_k = 8'h74;
            5'd11: alpha_k = 8'hE8;
            5'd12: alpha_k = 8'hCD;
            5'd13: alpha_k = 8'h87;
            5'd14: alpha_k = 8'h13;
            5'd15: alpha_k = 8'h26;
            5'd16: alpha_k = 8'h4C;
            5'd17: alpha_k = 8'h98;
            5'd18: alpha_k = 8'h2D;
            5'd19: alpha_k = 8'h5A;
            5'd20: alpha_k = 8'hB4;
            5'd21: alpha_k = 8'h75;
            5'd22: alpha_k = 8'hEA;
            5'd23: alpha_k = 8'hC9;
            5'd24: alpha_k = 8'h8F;
            5'd25: alpha_k = 8'h03;
            5'd26: alpha_k = 8'h06;
            5'd27: alpha_k = 8'h0C;
            5'd28: alpha_k = 8'h18;
            5'd29: alpha_k = 8'h30;
            5'd30: alpha_k = 8'h60;
            5'd31: alpha_k = 8'hC0;
            default: alpha_k = 8'h01;
        endcase
    end

    assign prod   = gf_mul(acc, alpha_k);
    assign accept = CS && !done;

    // CS low is a pause; once done, the block is frozen until the next reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc  <= 8'h00;
            cnt  <= 8'h00;
            done <= 1'b0;
        end else if (accept) begin
            acc <= prod ^ Msg_Rsv;
            if (cnt == LAST) done <= 1'b1;
            else             cnt  <= cnt + 8'd1;
        end
    end

    assign S_i = acc;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Randomized bench for rs_syndrome_calc against a log/antilog GF(2^8) power-sum model.
module tb_rs_syndrome_calc;

    logic       Clk;
    logic       Reset;
    logic [7:0] Msg_Rsv;
    logic [4:0] Alpha_i;
    logic       CS;
    logic       done;
    logic [7:0] S_i;

    int total = 0;
    int bad   = 0;

    int exp_t [255];
    int log_t [256];
    logic [7:0] blk [204];   // blk[i] is the i-th symbol sent, i.e. r_(203-i)

    rs_syndrome_calc #(.N(204)) dut (
        .Clk(Clk), .Reset(Reset), .Msg_Rsv(Msg_Rsv), .Alpha_i(Alpha_i),
        .CS(CS), .done(done), .S_i(S_i)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // S = sum_j r_j * alpha^(k*j)
    function automatic int model_syn(input int k);
        int s = 0;
        for (int j = 0; j < 204; j++)
            s = s ^ gmul(int'(blk[203 - j]), exp_t[(k * j) % 255]);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        CS    = 1'b0;
        #1;
        chk("rst_S", S_i, 0);
        chk("rst_done", done, 0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic send_block(input int k, input int gaps, output int done_edge);
        int gb[204];
        int edges;
        for (int i = 0; i < 204; i++) gb[i] = 0;
        for (int g = 0; g < gaps; g++) gb[$urandom_range(203, 1)]++;
        edges     = 0;
        done_edge = -1;
        Alpha_i   = 5'(k);
        for (int i = 0; i < 204; i++) begin
            for (int g = 0; g < gb[i]; g++) begin
                @(negedge Clk); CS = 1'b0; Msg_Rsv = 8'($urandom);
                @(posedge Clk); #1; edges++;
                if (done && done_edge < 0) done_edge = edges;
            end
            @(negedge Clk); CS = 1'b1; Msg_Rsv = blk[i];
            @(posedge Clk); #1; edges++;
            if (done && done_edge < 0) done_edge = edges;
            if (i == 202) chk("done_early", done, 0);
        end
        @(negedge Clk); CS = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 204; i++) blk[i] = 8'($urandom);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 204; i++) blk[i] = 8'h00;
    endtask

    // Non-systematic codeword c(x) = m(x) * g(x), g with roots alpha^0..alpha^15
    task automatic fill_codeword();
        int g[17];
        int m[188];
        int c[204];
        for (int i = 0; i < 17; i++) g[i] = 0;
        g[0] = 1;
        for (int r = 0; r < 16; r++) begin
            for (int d = 16; d >= 1; d--) g[d] = g[d - 1] ^ gmul(g[d], exp_t[r]);
            g[0] = gmul(g[0], exp_t[r]);
        end
        for (int i = 0; i < 188; i++) m[i] = int'($urandom_range(255, 0));
        for (int i = 0; i < 204; i++) c[i] = 0;
        for (int i = 0; i < 188; i++)
            for (int d = 0; d < 17; d++) c[i + d] = c[i + d] ^ gmul(m[i], g[d]);
        for (int i = 0; i < 204; i++) blk[i] = 8'(c[203 - i]);
    endtask

    initial begin
        int de, de2, x, s_ref, k;
        Reset = 1'b0; CS = 1'b0; Msg_Rsv = 8'h00; Alpha_i = 5'd0;

        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end

        #12;
        chk("init_S", S_i, 0);
        chk("init_done", done, 0);

        // all-zero block, done exactly at edge 204
        do_reset(); fill_zero();
        send_block(4, 0, de);
        chk("zero_S", S_i, 0);
        chk("zero_done_edge", de, 204);

        // only r_0
        do_reset(); fill_zero(); blk[203] = 8'h5A;
        send_block(4, 0, de);
        chk("r0_S", S_i, 'h5A);

        // only r_1 = 1 -> alpha^4
        do_reset(); fill_zero(); blk[202] = 8'h01;
        send_block(4, 0, de);
        chk("r1_k4_S", S_i, 'h10);

        // k=0: XOR of all symbols
        do_reset(); fill_rand();
        x = 0;
        for (int i = 0; i < 204; i++) x = x ^ int'(blk[i]);
        send_block(0, 0, de);
        chk("k0_xor_S", S_i, x);

        do_reset(); fill_zero(); blk[202] = 8'h01;
        send_block(16, 0, de);
        chk("r1_k16_S", S_i, 'h4C);

        // same random block with and without CS gaps
        fill_rand(); k = int'($urandom_range(31, 0));
        s_ref = model_syn(k);
        do_reset(); send_block(k, 0, de);
        chk("nogap_S", S_i, s_ref);
        chk("nogap_done_edge", de, 204);
        do_reset(); send_block(k, 10, de2);
        chk("gap_S", S_i, s_ref);
        chk("gap_done_edge", de2, 214);

        // frozen after done: extra symbols ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk); CS = 1'b1; Msg_Rsv = 8'($urandom);
        end
        @(negedge Clk); CS = 1'b0;
        chk("hold_S", S_i, s_ref);
        chk("hold_done", done, 1);

        // random roots across the whole table
        for (int t = 0; t < 6; t++) begin
            fill_rand(); k = int'($urandom_range(31, 0));
            do_reset(); send_block(k, int'($urandom_range(3, 0)), de);
            chk("rand_S", S_i, model_syn(k));
            chk("rand_done", done, 1);
        end

        // codewords give zero syndromes for the generator roots
        fill_codeword();
        for (int r = 0; r < 16; r++) begin
            do_reset(); send_block(r, 0, de);
            chk("cw_S", S_i, 0);
        end
        x = int'($urandom_range(203, 0));
        blk[x] = blk[x] ^ 8'(int'($urandom_range(255, 1)));
        for (int r = 0; r < 16; r += 5) begin
            do_reset(); send_block(r, 0, de);
            chk("cw_bad_nonzero", int'(S_i != 8'h00), 1);
            chk("cw_bad_S", S_i, model_syn(r));
        end

        // reset mid-block, then a clean restart
        fill_rand(); k = 7;
        do_reset();
        Alpha_i = 5'(k);
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk); CS = 1'b1; Msg_Rsv = blk[i];
        end
        do_reset();
        send_block(k, 0, de);
        chk("restart_S", S_i, model_syn(k));
        chk("restart_done_edge", de, 204);

        // reset after done clears immediately
        @(negedge Clk); Reset = 1'b0; #1;
        chk("post_done_rst_S", S_i, 0);
        chk("post_done_rst_done", done, 0);
        @(negedge Clk); Reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Single-syndrome calculator for the DVB-T Reed-Solomon RS(204,188) decoder over GF(2^8). It takes one received 8-bit symbol per clock, highest-degree coefficient first, and evaluates the received polynomial at alpha^k by Horner's rule, where k is the root index on Alpha_i. After 204 symbols it freezes the result on S_i and raises done. It is the first stage of the RS decoder; one instance is used per syndrome, or one instance is reused per block.

## Interface
Parameters:
- N, 204: symbols per codeword.
- Field polynomial, fixed: x^8+x^4+x^3+x^2+1 (0x11D), primitive element alpha = 0x02.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  reset, asynchronous and active-low. 0 clears all state immediately; 1 runs.
- Msg_Rsv  in  8  received symbol; sampled on each accepting edge.
- Alpha_i  in  5  root index k, 0..31; the evaluation point is alpha^k.
- CS  in  1  chip select / symbol valid. A symbol is accepted only when CS=1.
- done  out  1  high when S_i holds the final syndrome for the block.
- S_i  out  8  syndrome accumulator; the final value is valid while done=1.

## Operation
- Internal state:
  - 8-bit accumulator acc, driven directly onto S_i.
  - 8-bit symbol counter cnt, range 0..203.
  - done flag.
- Constant table: 32-entry combinational ROM giving alpha^k for k = Alpha_i. Reference entries:
  - alpha^0=0x01, alpha^1=0x02, alpha^4=0x10, alpha^8=0x1D
  - alpha^12=0xCD, alpha^15=0x26, alpha^16=0x4C
- GF multiplier: fully combinational 8x8 GF(2^8) multiply, reduced modulo 0x11D. Addition is bitwise XOR.
- Accept condition: Reset=1 and CS=1 and done=0. On an accepting edge:
  - acc <= gfmul(acc, alpha^Alpha_i) XOR Msg_Rsv.
  - If cnt=203: done <= 1 and cnt is held.
  - Otherwise cnt <= cnt+1.
- Symbol order: the first accepted symbol is r_203, the last is r_0. Result S = sum over j of r_j * alpha^(k*j).
- Hold conditions:
  - CS=0: acc, cnt and done hold. This is a pause, not an abort.
  - done=1: everything holds and further symbols are ignored until Reset goes low. There is no auto-restart.
- Alpha_i is used combinationally on every accepting edge. The environment must keep it constant for a whole block. A change mid-block gives an undefined syndrome but no lock-up.
- Reset low at any time, including mid-block or after done, clears acc, cnt and done to 0 asynchronously.
- A valid DVB-T codeword (generator roots alpha^0..alpha^15) yields S_i=0x00 for every Alpha_i in 0..15.

## Timing
- Reset values: S_i=0x00, done=0, internal cnt=0.
- Throughput: one symbol per clock while CS=1.
- Latency:
  - The 204th accepting edge updates S_i to its final value and sets done=1 on that same edge. Both are registered outputs.
  - With CS held at 1 from the first accepting edge E1, done rises at edge E204.
- Each CS=0 cycle inside the block delays done by exactly one cycle.
- done remains 1 and S_i remains stable indefinitely until Reset is asserted.
- Reset is asynchronous: outputs go to reset values without waiting for a clock. The release is sampled at the next rising edge, which is the first possible accepting edge.
- No combinational path from inputs to outputs.

## Test plan
- All-zero block: Alpha_i=4, CS=1, 204 symbols of 0x00 -> S_i=0x00; done rises exactly at edge 204, not at edge 203.
- Last symbol only: Alpha_i=4, r_203..r_1=0x00, r_0=0x5A -> S_i=0x5A. Second case with r_1=0x01 and all others 0 -> S_i=0x10.
- Alpha_i=0: 204 random symbols -> S_i equals the XOR of all 204 symbols. Repeat with Alpha_i=16 and r_1=0x01 only -> S_i=0x4C.
- CS gaps: the same random block with CS=0 for 10 scattered cycles -> same S_i as the gap-free run; done is 10 cycles later. Symbols presented while CS=0 are ignored.
- Codeword check: RS(204,188) encoder output fed for each Alpha_i in 0..15 -> S_i=0x00. One symbol corrupted -> S_i nonzero.
- Reset: assert Reset=0 at symbol 100 -> S_i=0 and done=0 immediately; a restarted full block gives correct results. After done=1, extra symbols leave S_i and done unchanged.
